// File: rtl/jk_pkg.sv
// jk_pkg: shared mode encoding for the JK universal register
//   MODE_W - width of the MODE port
//   mode_e - JK, D, T, COUNT operating modes
package jk_pkg;
    localparam int MODE_W = 2;
    typedef enum logic [MODE_W-1:0] {
        JK    = 2'd0,
        D     = 2'd1,
        T     = 2'd2,
        COUNT = 2'd3
    } mode_e;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one-bit JK flip-flop with enable, sync preset and async clear
//   CLK, CLR   - rising-edge clock, async active-high clear to reset_bit
//   PR         - sync preset to preset_bit, overrides EN
//   EN         - clock enable
//   J, K       - JK inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   Q          - state
module jk_cell (
    input  logic CLK,
    input  logic CLR,
    input  logic PR,
    input  logic EN,
    input  logic J,
    input  logic K,
    input  logic preset_bit,
    input  logic reset_bit,
    output logic Q
);
    always_ff @(posedge CLK or posedge CLR)
        if (CLR)
            Q <= reset_bit;
        else if (PR)
            Q <= preset_bit;
        else if (EN)
            Q <= (J & ~Q) | (~K & Q);
endmodule

// File: rtl/jk_universal_reg.sv
// jk_universal_reg: multi-bit JK register with D, T and up/down count modes
//   CLK, CLR - rising-edge clock, async active-high clear to RESET_VAL
//   PR       - sync preset to PRESET_VAL (beats EN and MODE)
//   EN       - clock enable
//   MODE     - 0 JK, 1 D, 2 T, 3 COUNT; UP selects count direction
//   J, K     - per-bit JK inputs; J doubles as D/T data
//   Q, Q_bar - state and its complement
//   TC       - terminal count in COUNT mode
//   CHG      - one-cycle pulse after an edge that changed Q
module jk_universal_reg import jk_pkg::*; #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              PR,
    input  logic              EN,
    input  logic [MODE_W-1:0] MODE,
    input  logic              UP,
    input  logic [WIDTH-1:0]  J,
    input  logic [WIDTH-1:0]  K,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Q_bar,
    output logic              TC,
    output logic              CHG
);
    logic [WIDTH-1:0] all1, all0, te, cj, ck, nq;
    // Ripple-free toggle enables: bit i toggles when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        all1    = '0;
        all0    = '0;
        all1[0] = 1'b1;
        all0[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            all1[i] = all1[i-1] & Q[i-1];
            all0[i] = all0[i-1] & ~Q[i-1];
        end
        te = UP ? all1 : all0;
    end
    // Each mode expressed as JK drive: D -> J=d,K=~d; T -> J=K=t; COUNT -> J=K=te
    assign cj = MODE == COUNT ? te : J;
    assign ck = MODE == JK ? K : MODE == D ? ~J : MODE == T ? J : te;
    // Next state mirrored here only to detect change for CHG
    assign nq = PR ? PRESET_VAL : EN ? (cj & ~Q) | (~ck & Q) : Q;
    assign Q_bar = ~Q;
    assign TC = MODE == COUNT && (UP ? &Q : ~|Q);
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            jk_cell u_cell (
                .CLK        (CLK),
                .CLR        (CLR),
                .PR         (PR),
                .EN         (EN),
                .J          (cj[i]),
                .K          (ck[i]),
                .preset_bit (PRESET_VAL[i]),
                .reset_bit  (RESET_VAL[i]),
                .Q          (Q[i])
            );
        end
    endgenerate
    always_ff @(posedge CLK or posedge CLR)
        if (CLR)
            CHG <= 1'b0;
        else
            CHG <= nq != Q;
endmodule
